// File: rtl/udp_encode.sv
// Byte-serial UDP header builder: emits the 8-byte header MSB-first, then forwards payload bytes.
// Define UDP_CHECKSUM_EN to add the one's-complement checksum side-channel (csum_seed/csum_out/csum_valid).
module udp_encode #(
    parameter int unsigned MAX_PAYLOAD = 1472
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [15:0] payload_len,
    output logic        busy,
    output logic        err,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        done
`ifdef UDP_CHECKSUM_EN
    ,
    input  logic [15:0] csum_seed,
    output logic [15:0] csum_out,
    output logic        csum_valid
`endif
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

    typedef enum logic [1:0] {IDLE, HDR, PAY, FIN} state_t;

    state_t      state, state_next;
    logic [15:0] src_q, dst_q, len_q, rem;
    logic [2:0]  cnt;
    logic [7:0]  hdr_next;
    logic        accept, reject, out_fire, in_fire;

    assign accept   = (state == IDLE) && start && (payload_len <= MAX_LEN);
    assign reject   = (state == IDLE) && start && (payload_len > MAX_LEN);
    assign out_fire = out_valid && out_ready;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        in_ready   = 1'b0;
        case (state)
            IDLE: if (accept) state_next = HDR;
            HDR: begin
                busy = 1'b1;
                if (out_fire && cnt == 3'd7) state_next = (rem == 16'd0) ? FIN : PAY;
            end
            PAY: begin
                busy     = 1'b1;
                in_ready = (rem != 16'd0) && (!out_valid || out_ready);
                if (out_fire && out_last) state_next = FIN;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Byte following header index cnt; checksum bytes 6-7 are always zero on the wire.
    always_comb begin
        hdr_next = 8'h00;
        case (cnt)
            3'd0: hdr_next = src_q[7:0];
            3'd1: hdr_next = dst_q[15:8];
            3'd2: hdr_next = dst_q[7:0];
            3'd3: hdr_next = len_q[15:8];
            3'd4: hdr_next = len_q[7:0];
            default: hdr_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            rem       <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            err <= reject;
            case (state)
                IDLE: if (accept) begin
                    src_q     <= src_port;
                    dst_q     <= dst_port;
                    len_q     <= payload_len + 16'd8;
                    rem       <= payload_len;
                    cnt       <= '0;
                    out_data  <= src_port[15:8];
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                end
                HDR: if (out_fire) begin
                    if (cnt == 3'd7) begin
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end else begin
                        cnt      <= cnt + 3'd1;
                        out_data <= hdr_next;
                        out_last <= (cnt == 3'd6) && (rem == 16'd0);
                    end
                end
                PAY: begin
                    // Skid register: a new byte may replace one handshaking in the same cycle.
                    if (in_fire) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        out_last  <= (rem == 16'd1);
                        rem       <= rem - 16'd1;
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef UDP_CHECKSUM_EN
    logic [15:0] sum;
    logic [7:0]  pend;
    logic        odd;

    function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            pend <= '0;
            odd  <= 1'b0;
        end else if (accept) begin
            sum <= oc_add(oc_add(oc_add(csum_seed, src_port), dst_port), payload_len + 16'd8);
            odd <= 1'b0;
        end else if (in_fire) begin
            // Odd trailing byte is folded in immediately, padded low with zero.
            if (!odd) begin
                pend <= in_data;
                if (rem == 16'd1) sum <= oc_add(sum, {in_data, 8'h00});
            end else begin
                sum <= oc_add(sum, {pend, in_data});
            end
            odd <= !odd;
        end
    end

    assign csum_out   = (sum == 16'hFFFF) ? 16'hFFFF : ~sum;
    assign csum_valid = done;
`endif

endmodule
